// File: rtl/wb_pkg.sv
// wb_pkg: shared write-buffer types, widths and the parity helper used by both
// the write buffer and its drain port.
package wb_pkg;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        HOLD    = 2'd2,
        PRESENT = 2'd3
    } drain_state_t;

    function automatic logic calc_parity(input logic [WB_DW-1:0] data);
        return ^data;
    endfunction
endpackage

// File: rtl/wb_drain_countdown.sv
// wb_drain_countdown: loadable down-counter timing the device-busy hold of one word.
module wb_drain_countdown #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         HRESETn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_one_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or negedge HRESETn)
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign is_one_o = cnt_q == W'(1);
endmodule

// File: rtl/wb_drain_port.sv
// wb_drain_port: drains the write-buffer FIFO one word per YREQ/YACK handshake,
// holds it for busy_cycles, then offers it on valid/ready. Parity checking is
// built only when WB_DRAIN_PARITY_CHECK_EN is defined.
module wb_drain_port
    import wb_pkg::*;
#(
    parameter int DW     = WB_DW,
    parameter int BUSY_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              HRESETn,
    input  logic              YREQ,
    input  logic [DW-1:0]     YDATA,
    input  logic              YPARITY,
    input  logic              PARTYSEL,
    output logic              YACK,
    input  logic [BUSY_W-1:0] busy_cycles,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy
);
    drain_state_t state_q;
    logic         hold_done;

    wb_drain_countdown #(.W(BUSY_W)) u_cnt (
        .clk       (clk),
        .HRESETn   (HRESETn),
        .load_i    (state_q == ACK),
        .load_val_i(busy_cycles),
        .dec_i     (state_q == HOLD),
        .is_one_o  (hold_done)
    );

    // Outputs are registered alongside the state so nothing is combinational from YREQ.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            YACK       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            word_count <= '0;
            busy       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (YREQ) begin
                    state_q    <= ACK;
                    YACK       <= 1'b1;
                    dout       <= YDATA;
                    word_count <= word_count + CNT_W'(1);
                    busy       <= 1'b1;
                end
                ACK: begin
                    YACK <= 1'b0;
                    if (busy_cycles != '0) state_q <= HOLD;
                    else begin
                        state_q    <= PRESENT;
                        dout_valid <= 1'b1;
                    end
                end
                HOLD: if (hold_done) begin
                    state_q    <= PRESENT;
                    dout_valid <= 1'b1;
                end
                PRESENT: if (dout_ready) begin
                    state_q    <= IDLE;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WB_DRAIN_PARITY_CHECK_EN
    logic mismatch;

    assign mismatch = (state_q == IDLE) && YREQ && PARTYSEL && (YPARITY != calc_parity(YDATA));

    // Clear takes priority over a mismatch landing on the same edge.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            parity_err <= 1'b0;
            err_count  <= '0;
        end else if (err_clr) begin
            parity_err <= 1'b0;
            err_count  <= '0;
        end else if (mismatch) begin
            parity_err <= 1'b1;
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
        end
    end
`else
    logic unused_parity;

    assign unused_parity = ^{YPARITY, PARTYSEL, err_clr};
    assign parity_err    = 1'b0;
    assign err_count     = '0;
`endif
endmodule

// File: tb/tb_wb_drain_port.sv
// tb_wb_drain_port: directed vectors plus hand sequences for hold, parity, wrap and reset.
// A narrow-counter second instance exercises wrap and saturation within a short run.
module tb_wb_drain_port;
    import wb_pkg::*;

`ifdef WB_DRAIN_PARITY_CHECK_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0, HRESETn = 1'b0, YREQ = 1'b0, YPARITY = 1'b0, PARTYSEL = 1'b0;
    logic        dout_ready = 1'b0, err_clr = 1'b0;
    logic [31:0] YDATA = '0;
    logic [7:0]  busy_cycles = '0;
    logic        YACK, dout_valid, parity_err, busy;
    logic [31:0] dout;
    logic [15:0] err_count, word_count;
    logic        s_YACK, s_dout_valid, s_parity_err, s_busy;
    logic [31:0] s_dout;
    logic [3:0]  s_err_count, s_word_count;

    int checks = 0, errors = 0;

    wb_drain_port dut (
        .clk(clk), .HRESETn(HRESETn), .YREQ(YREQ), .YDATA(YDATA), .YPARITY(YPARITY),
        .PARTYSEL(PARTYSEL), .YACK(YACK), .busy_cycles(busy_cycles), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .parity_err(parity_err),
        .err_clr(err_clr), .err_count(err_count), .word_count(word_count), .busy(busy)
    );

    wb_drain_port #(.CNT_W(4)) dut_small (
        .clk(clk), .HRESETn(HRESETn), .YREQ(YREQ), .YDATA(YDATA), .YPARITY(YPARITY),
        .PARTYSEL(PARTYSEL), .YACK(s_YACK), .busy_cycles(busy_cycles), .dout(s_dout),
        .dout_valid(s_dout_valid), .dout_ready(dout_ready), .parity_err(s_parity_err),
        .err_clr(err_clr), .err_count(s_err_count), .word_count(s_word_count), .busy(s_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
    endtask

    // One full word with zero hold time and the target always ready.
    task automatic send(input logic [31:0] d, input logic par, input logic ps, input logic clr);
        YREQ = 1'b1; YDATA = d; YPARITY = par; PARTYSEL = ps; err_clr = clr;
        busy_cycles = '0; dout_ready = 1'b1;
        step();
        chk("send_ack", {31'd0, YACK}, 32'd1);
        YREQ = 1'b0; err_clr = 1'b0;
        step();
        chk("send_valid", {31'd0, dout_valid}, 32'd1);
        chk("send_dout", dout, d);
        step();
    endtask

    typedef struct {
        logic        yreq;
        logic [31:0] data;
        logic        yack;
        logic        valid;
        logic        bsy;
        logic [31:0] dout;
        logic [15:0] wc;
    } vec_t;

    vec_t tv[9];

    initial begin
        int n;
        tv[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'd1};
        tv[1] = '{1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 16'd1};
        tv[2] = '{1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 16'd1};
        tv[3] = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'h12345678, 16'd2};
        tv[4] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 1'b1, 32'h12345678, 16'd2};
        tv[5] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 16'd2};
        tv[6] = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 16'd3};
        tv[7] = '{1'b0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 16'd3};
        tv[8] = '{1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 16'd3};

        // Reset held with YREQ asserted
        YREQ = 1'b1; YDATA = 32'h55; YPARITY = ^YDATA; dout_ready = 1'b1;
        step(); step();
        chk("t1_yack", {31'd0, YACK}, 32'd0);
        chk("t1_dout", dout, 32'd0);
        chk("t1_valid", {31'd0, dout_valid}, 32'd0);
        chk("t1_wc", {16'd0, word_count}, 32'd0);
        chk("t1_err", {16'd0, err_count}, 32'd0);
        HRESETn = 1'b1;
        n = 0;
        while (!YACK && n < 3) begin
            step();
            n++;
        end
        chk("t1_ack_seen", {31'd0, YACK}, 32'd1);
        chk("t1_ack_latency_ok", {31'd0, n <= 2}, 32'd1);
        YREQ = 1'b0;
        step();
        chk("t1_ack_once", {31'd0, YACK}, 32'd0);

        // Zero hold time, target always ready
        do_reset();
        PARTYSEL = 1'b1; busy_cycles = '0; dout_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            YREQ = tv[i].yreq; YDATA = tv[i].data; YPARITY = ^tv[i].data;
            step();
            chk($sformatf("t2_yack[%0d]", i), {31'd0, YACK}, {31'd0, tv[i].yack});
            chk($sformatf("t2_valid[%0d]", i), {31'd0, dout_valid}, {31'd0, tv[i].valid});
            chk($sformatf("t2_busy[%0d]", i), {31'd0, busy}, {31'd0, tv[i].bsy});
            chk($sformatf("t2_dout[%0d]", i), dout, tv[i].dout);
            chk($sformatf("t2_wc[%0d]", i), {16'd0, word_count}, {16'd0, tv[i].wc});
        end
        chk("t2_err", {16'd0, err_count}, 32'd0);

        // Five-cycle hold, then target stalls four cycles
        do_reset();
        dout_ready = 1'b0; YREQ = 1'b1; YDATA = 32'hC0FFEE00; YPARITY = ^YDATA; busy_cycles = 8'd5;
        step();
        chk("t3_ack", {31'd0, YACK}, 32'd1);
        YDATA = 32'h11111111; YPARITY = ^YDATA;
        step();
        busy_cycles = 8'd9;
        chk("t3_hold_valid0", {31'd0, dout_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t3_hold_valid[%0d]", i), {31'd0, dout_valid}, 32'd0);
            chk($sformatf("t3_hold_yack[%0d]", i), {31'd0, YACK}, 32'd0);
            chk($sformatf("t3_hold_dout[%0d]", i), dout, 32'hC0FFEE00);
        end
        step();
        chk("t3_present", {31'd0, dout_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t3_stall_valid[%0d]", i), {31'd0, dout_valid}, 32'd1);
            chk($sformatf("t3_stall_dout[%0d]", i), dout, 32'hC0FFEE00);
            chk($sformatf("t3_stall_yack[%0d]", i), {31'd0, YACK}, 32'd0);
        end
        dout_ready = 1'b1;
        step();
        chk("t3_idle_valid", {31'd0, dout_valid}, 32'd0);
        chk("t3_idle_yack", {31'd0, YACK}, 32'd0);
        chk("t3_idle_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t3_second_ack", {31'd0, YACK}, 32'd1);
        chk("t3_second_dout", dout, 32'h11111111);
        YREQ = 1'b0; busy_cycles = '0;
        step(); step();

        // Parity errors, then clear racing a fourth bad word
        do_reset();
        send(32'h00000001, 1'b0, 1'b1, 1'b0);
        send(32'h00000003, 1'b1, 1'b1, 1'b0);
        send(32'hF0F0F0F1, 1'b0, 1'b1, 1'b0);
        chk("t4_err_count", {16'd0, err_count}, PEN ? 32'd3 : 32'd0);
        chk("t4_parity_err", {31'd0, parity_err}, {31'd0, PEN});
        send(32'h00000007, 1'b0, 1'b1, 1'b1);
        chk("t4_clr_count", {16'd0, err_count}, 32'd0);
        chk("t4_clr_flag", {31'd0, parity_err}, 32'd0);

        // Parity ignored, then counter wrap and saturation on the narrow instance
        send(32'h00000001, 1'b0, 1'b0, 1'b0);
        send(32'h00000002, 1'b0, 1'b0, 1'b0);
        chk("t5_ignored_count", {16'd0, err_count}, 32'd0);
        chk("t5_ignored_flag", {31'd0, parity_err}, 32'd0);
        do_reset();
        for (int i = 0; i < 17; i++) send(32'h00000001, 1'b0, 1'b1, 1'b0);
        chk("t5_small_wrap", {28'd0, s_word_count}, 32'd1);
        chk("t5_wc17", {16'd0, word_count}, 32'd17);
        chk("t5_small_sat", {28'd0, s_err_count}, PEN ? 32'd15 : 32'd0);
        chk("t5_err17", {16'd0, err_count}, PEN ? 32'd17 : 32'd0);

        // Reset asserted during hold
        do_reset();
        dout_ready = 1'b1; YREQ = 1'b1; YDATA = 32'hBADC0DE0; busy_cycles = 8'd10;
        step();
        YREQ = 1'b0;
        step(); step();
        chk("t6_in_hold", {30'd0, busy, dout_valid}, 32'd2);
        #2 HRESETn = 1'b0;
        #1;
        chk("t6_rst_yack", {31'd0, YACK}, 32'd0);
        chk("t6_rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("t6_rst_dout", dout, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_wc", {16'd0, word_count}, 32'd0);
        step();
        HRESETn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("t6_no_ack[%0d]", i), {30'd0, YACK, busy}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
